// File: rtl/route_lut_writer.sv
// Configuration-side writer for the switch routing table: owns the entries,
// serves write/read/clear-all commands and exposes the table as flat LUT buses.
module route_lut_writer #(
  parameter int NUM_ENTRIES  = 32,
  parameter int NODE_W       = 8,
  parameter int OUT_SEL_W    = 8,
  parameter int NUM_OUTPORTS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [1:0]                        cfg_op,
  input  logic [$clog2(NUM_ENTRIES):0]      cfg_index,
  input  logic [NODE_W-1:0]                 cfg_req,
  input  logic [NODE_W-1:0]                 cfg_dest,
  input  logic [OUT_SEL_W-1:0]              cfg_out_sel,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_err,
  output logic [2*NODE_W+OUT_SEL_W-1:0]     rsp_data,
  output logic [NUM_ENTRIES*NODE_W-1:0]     lut_req,
  output logic [NUM_ENTRIES*NODE_W-1:0]     lut_dest,
  output logic [NUM_ENTRIES*OUT_SEL_W-1:0]  lut_out_sel,
  output logic                              lut_update,
  output logic                              busy
);

  localparam int IDX_W = $clog2(NUM_ENTRIES) + 1;
  localparam int CNT_W = $clog2(NUM_ENTRIES);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  typedef enum logic [1:0] {IDLE, CLEAR, RESP} state_t;

  state_t state_q, state_d;

  logic [NODE_W-1:0]    req_q  [NUM_ENTRIES];
  logic [NODE_W-1:0]    dest_q [NUM_ENTRIES];
  logic [OUT_SEL_W-1:0] osel_q [NUM_ENTRIES];

  logic [CNT_W-1:0] clr_cnt_q;
  logic             lut_update_q;
  logic             rsp_err_q;
  logic [2*NODE_W+OUT_SEL_W-1:0] rsp_data_q;

  logic             accept;
  logic             idx_ok;
  logic             sel_ok;
  logic [CNT_W-1:0] idx_lo;
  logic             wr_en;
  logic             clr_last;
  logic             err_d;
  logic [2*NODE_W+OUT_SEL_W-1:0] data_d;

  // Held low during reset even though the state register already reads IDLE.
  assign cfg_ready  = (state_q == IDLE) && !rst;
  assign accept     = cfg_valid && cfg_ready;
  assign idx_ok     = cfg_index < IDX_W'(NUM_ENTRIES);
  assign sel_ok     = cfg_out_sel < OUT_SEL_W'(NUM_OUTPORTS);
  assign idx_lo     = cfg_index[CNT_W-1:0];
  assign wr_en      = accept && (cfg_op == OP_WRITE) && idx_ok && sel_ok;
  assign clr_last   = (state_q == CLEAR) && (clr_cnt_q == CNT_W'(NUM_ENTRIES - 1));

  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q == CLEAR);
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_data_q;
  assign lut_update = lut_update_q;

  always_comb begin
    err_d  = 1'b1;
    data_d = '0;
    case (cfg_op)
      OP_WRITE: err_d = !(idx_ok && sel_ok);
      OP_READ: begin
        err_d = !idx_ok;
        if (idx_ok) data_d = {req_q[idx_lo], dest_q[idx_lo], osel_q[idx_lo]};
      end
      OP_CLEAR: err_d = 1'b0;
      default:  err_d = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (cfg_op == OP_CLEAR) ? CLEAR : RESP;
      CLEAR:   if (clr_last) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      clr_cnt_q    <= '0;
      lut_update_q <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      lut_update_q <= wr_en || clr_last;
      if (accept) begin
        rsp_err_q  <= err_d;
        rsp_data_q <= data_d;
      end
      if (accept && cfg_op == OP_CLEAR) clr_cnt_q <= '0;
      else if (state_q == CLEAR)        clr_cnt_q <= clr_cnt_q + CNT_W'(1);
    end
  end

  // A clear walks one entry per cycle, so route compute may see a partial table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        req_q[i]  <= '0;
        dest_q[i] <= '0;
        osel_q[i] <= '0;
      end
    end else if (wr_en) begin
      req_q[idx_lo]  <= cfg_req;
      dest_q[idx_lo] <= cfg_dest;
      osel_q[idx_lo] <= cfg_out_sel;
    end else if (state_q == CLEAR) begin
      req_q[clr_cnt_q]  <= '0;
      dest_q[clr_cnt_q] <= '0;
      osel_q[clr_cnt_q] <= '0;
    end
  end

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_pack
    assign lut_req[g*NODE_W +: NODE_W]           = req_q[g];
    assign lut_dest[g*NODE_W +: NODE_W]          = dest_q[g];
    assign lut_out_sel[g*OUT_SEL_W +: OUT_SEL_W] = osel_q[g];
  end

endmodule

// File: tb/tb_route_lut_writer.sv
// Directed bench for route_lut_writer: write/read/error paths, response hold,
// clear-all timing, reset mid-clear and back-to-back command spacing.
module tb_route_lut_writer;

  logic         clk;
  logic         rst;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [1:0]   cfg_op;
  logic [5:0]   cfg_index;
  logic [7:0]   cfg_req;
  logic [7:0]   cfg_dest;
  logic [7:0]   cfg_out_sel;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_err;
  logic [23:0]  rsp_data;
  logic [255:0] lut_req;
  logic [255:0] lut_dest;
  logic [255:0] lut_out_sel;
  logic         lut_update;
  logic         busy;

  int errors = 0;
  int checks = 0;

  route_lut_writer dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_op(cfg_op),
    .cfg_index(cfg_index), .cfg_req(cfg_req), .cfg_dest(cfg_dest),
    .cfg_out_sel(cfg_out_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
    .rsp_data(rsp_data),
    .lut_req(lut_req), .lut_dest(lut_dest), .lut_out_sel(lut_out_sel),
    .lut_update(lut_update), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single edge; returns one cycle after the accept.
  task automatic do_cmd(input logic [1:0] op, input logic [5:0] idx,
                        input logic [7:0] rq, input logic [7:0] ds, input logic [7:0] os);
    cfg_valid = 1'b1; cfg_op = op; cfg_index = idx;
    cfg_req = rq; cfg_dest = ds; cfg_out_sel = os;
    chk("cmd_ready_before_accept", 256'(cfg_ready), 256'(1));
    tick();
    cfg_valid = 1'b0;
  endtask

  // Waits (bounded) for the response, then acknowledges it.
  task automatic ack_rsp();
    int n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk("rsp_arrives", 256'(rsp_valid), 256'(1));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  logic [255:0] exp_req, exp_dest, exp_osel;
  logic [23:0]  held;
  int k, busy_cnt, upd_cnt, acc;

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_op = 2'b00; cfg_index = '0;
    cfg_req = '0; cfg_dest = '0; cfg_out_sel = '0; rsp_ready = 1'b0;
    #1;
    chk("rst_cfg_ready", 256'(cfg_ready), 256'(0));
    chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_lut_update", 256'(lut_update), 256'(0));
    chk("rst_lut_req", lut_req, 256'(0));
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 256'(cfg_ready), 256'(1));

    // Write idx 3
    do_cmd(2'b00, 6'd3, 8'h05, 8'h0A, 8'd2);
    chk("wr_ready_drop", 256'(cfg_ready), 256'(0));
    chk("wr_lut_dest3", 256'(lut_dest[3*8 +: 8]), 256'(8'h0A));
    chk("wr_lut_req3", 256'(lut_req[3*8 +: 8]), 256'(8'h05));
    chk("wr_lut_osel3", 256'(lut_out_sel[3*8 +: 8]), 256'(8'h02));
    chk("wr_lut_update", 256'(lut_update), 256'(1));
    chk("wr_rsp_valid", 256'(rsp_valid), 256'(1));
    chk("wr_rsp_err", 256'(rsp_err), 256'(0));
    chk("wr_rsp_data", 256'(rsp_data), 256'(0));
    ack_rsp();
    chk("wr_back_idle", 256'(cfg_ready), 256'(1));
    chk("wr_update_once", 256'(lut_update), 256'(0));

    // Read idx 3 and hold the response for 5 cycles while a stray command is offered
    do_cmd(2'b01, 6'd3, 8'h00, 8'h00, 8'h00);
    chk("rd_data", 256'(rsp_data), 256'(24'h050A02));
    chk("rd_err", 256'(rsp_err), 256'(0));
    cfg_valid = 1'b1; cfg_op = 2'b00; cfg_index = 6'd3;
    cfg_req = 8'hEE; cfg_dest = 8'hEE; cfg_out_sel = 8'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_data", 256'(rsp_data), 256'(24'h050A02));
      chk("hold_ready", 256'(cfg_ready), 256'(0));
      chk("hold_valid", 256'(rsp_valid), 256'(1));
    end
    cfg_valid = 1'b0;
    chk("hold_ignored_dest3", 256'(lut_dest[3*8 +: 8]), 256'(8'h0A));
    ack_rsp();

    // Bad index and bad out_sel
    do_cmd(2'b00, 6'd32, 8'h11, 8'h22, 8'd1);
    chk("badidx_err", 256'(rsp_err), 256'(1));
    chk("badidx_no_update", 256'(lut_update), 256'(0));
    ack_rsp();
    do_cmd(2'b00, 6'd4, 8'h11, 8'h22, 8'd4);
    chk("badsel_err", 256'(rsp_err), 256'(1));
    chk("badsel_no_update", 256'(lut_update), 256'(0));
    chk("badsel_entry4", 256'(lut_req[4*8 +: 8]), 256'(0));
    ack_rsp();
    do_cmd(2'b01, 6'd40, 8'h00, 8'h00, 8'h00);
    chk("rd_badidx_err", 256'(rsp_err), 256'(1));
    chk("rd_badidx_data", 256'(rsp_data), 256'(0));
    ack_rsp();

    // Fill all entries, then clear-all
    exp_req = '0; exp_dest = '0; exp_osel = '0;
    for (int i = 0; i < 32; i++) begin
      do_cmd(2'b00, 6'(i), 8'(i + 1), 8'(i + 8'h40), 8'(i % 4));
      exp_req[i*8 +: 8]  = 8'(i + 1);
      exp_dest[i*8 +: 8] = 8'(i + 8'h40);
      exp_osel[i*8 +: 8] = 8'(i % 4);
      ack_rsp();
    end
    chk("fill_req", lut_req, exp_req);
    chk("fill_dest", lut_dest, exp_dest);
    chk("fill_osel", lut_out_sel, exp_osel);

    do_cmd(2'b10, 6'd0, 8'h00, 8'h00, 8'h00);
    k = 1; busy_cnt = 0; upd_cnt = 0;
    while (!rsp_valid && k < 100) begin
      busy_cnt += int'(busy);
      upd_cnt  += int'(lut_update);
      tick();
      k++;
    end
    upd_cnt += int'(lut_update);
    chk("clr_latency", 256'(k), 256'(33));
    chk("clr_busy_cycles", 256'(busy_cnt), 256'(32));
    chk("clr_update_pulse", 256'(upd_cnt), 256'(1));
    chk("clr_busy_low", 256'(busy), 256'(0));
    chk("clr_err", 256'(rsp_err), 256'(0));
    chk("clr_req_zero", lut_req, 256'(0));
    chk("clr_dest_zero", lut_dest, 256'(0));
    chk("clr_osel_zero", lut_out_sel, 256'(0));
    ack_rsp();
    chk("clr_update_once", 256'(lut_update), 256'(0));

    // Reset in the middle of a clear-all
    do_cmd(2'b00, 6'd20, 8'h33, 8'h44, 8'd3);
    ack_rsp();
    do_cmd(2'b00, 6'd25, 8'h55, 8'h66, 8'd1);
    ack_rsp();
    do_cmd(2'b10, 6'd0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 9; i++) tick();
    chk("midclr_busy", 256'(busy), 256'(1));
    rst = 1'b1;
    #1;
    chk("midclr_rst_ready", 256'(cfg_ready), 256'(0));
    chk("midclr_rst_busy", 256'(busy), 256'(0));
    chk("midclr_rst_valid", 256'(rsp_valid), 256'(0));
    chk("midclr_rst_req", lut_req, 256'(0));
    chk("midclr_rst_dest", lut_dest, 256'(0));
    chk("midclr_rst_update", 256'(lut_update), 256'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("midclr_post_ready", 256'(cfg_ready), 256'(1));
    tick();
    chk("midclr_no_update", 256'(lut_update), 256'(0));
    do_cmd(2'b01, 6'd20, 8'h00, 8'h00, 8'h00);
    chk("midclr_rd20_data", 256'(rsp_data), 256'(0));
    chk("midclr_rd20_err", 256'(rsp_err), 256'(0));
    ack_rsp();

    // Illegal op
    do_cmd(2'b11, 6'd1, 8'h00, 8'h00, 8'h00);
    chk("op11_err", 256'(rsp_err), 256'(1));
    chk("op11_data", 256'(rsp_data), 256'(0));
    ack_rsp();

    // Back-to-back writes with rsp_ready held high
    rsp_ready = 1'b1; cfg_valid = 1'b1; cfg_op = 2'b00; acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (cfg_ready) begin
        cfg_index = 6'(10 + acc); cfg_req = 8'(8'h80 + acc);
        cfg_dest = 8'(8'h90 + acc); cfg_out_sel = 8'd1;
        acc++;
      end
      tick();
    end
    cfg_valid = 1'b0;
    tick();
    rsp_ready = 1'b0;
    chk("b2b_accepts", 256'(acc), 256'(5));
    for (int i = 0; i < 5; i++) begin
      chk("b2b_req", 256'(lut_req[(10+i)*8 +: 8]), 256'(8'(8'h80 + i)));
      chk("b2b_dest", 256'(lut_dest[(10+i)*8 +: 8]), 256'(8'(8'h90 + i)));
    end
    chk("b2b_idle", 256'(cfg_ready), 256'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/route_lut_writer.md
Name: route_lut_writer

Overview:
- Configuration-side writer for the switch routing table, which is read combinationally by the route-compute stage.
- Accepts single-outstanding config commands over a valid/ready channel: write, read, clear-all.
- Owns the table storage and drives it as flat LUT outputs to the register bank.
- Returns exactly one response per accepted command.

Parameters:
- NUM_ENTRIES, 32, number of route table entries; must be a power of 2.
- NODE_W, 8, width of node_id_t fields (req, dest).
- OUT_SEL_W, 8, width of the out_sel field.
- NUM_OUTPORTS, 4, legal out_sel range is 0..NUM_OUTPORTS-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  command valid
- cfg_ready  out  1  command accept; handshake completes when cfg_valid && cfg_ready
- cfg_op  in  2  command: 00 write, 01 read, 10 clear-all, 11 illegal
- cfg_index  in  $clog2(NUM_ENTRIES)+1  entry index (MSB exists so out-of-range values are detectable)
- cfg_req  in  NODE_W  req field for write
- cfg_dest  in  NODE_W  dest field for write
- cfg_out_sel  in  OUT_SEL_W  out_sel field for write
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_err  out  1  command rejected
- rsp_data  out  2*NODE_W+OUT_SEL_W  {req,dest,out_sel}; read data, zero for other ops
- lut_req  out  NUM_ENTRIES*NODE_W  entry i req at [i*NODE_W+:NODE_W]
- lut_dest  out  NUM_ENTRIES*NODE_W  entry i dest, same packing
- lut_out_sel  out  NUM_ENTRIES*OUT_SEL_W  entry i out_sel
- lut_update  out  1  one-cycle pulse after table contents change
- busy  out  1  high while a clear-all is in progress

Behaviour:
- Reset (async, rst=1):
  - All entries become 0.
  - FSM goes to IDLE.
  - cfg_ready=0 while rst is asserted.
  - rsp_valid=0, rsp_err=0, rsp_data=0, lut_update=0, busy=0.
- After reset is released, cfg_ready=1 in IDLE.
- Entry field value 0 in req or dest is a wildcard for route compute. An all-zero entry therefore matches everything and routes to port 0.
- FSM states: IDLE, CLEAR, RESP.
- IDLE: cfg_ready=1. On handshake:
  - write, index < NUM_ENTRIES, out_sel < NUM_OUTPORTS:
    - entry written at the accepting edge, visible on the lut_* outputs the next cycle;
    - lut_update=1 for that one cycle;
    - go to RESP with err=0, data=0.
  - write with bad index or bad out_sel: table unchanged, no lut_update; RESP with err=1.
  - read, index valid: RESP with rsp_data = entry contents at the accept edge, err=0.
  - read, index invalid: RESP with err=1, data=0.
  - clear-all: go to CLEAR with counter=0 and busy=1.
  - op 11: RESP with err=1.
- CLEAR:
  - cfg_ready=0.
  - Zeroes entry[counter] each cycle and increments the counter, so it takes NUM_ENTRIES cycles.
  - After the last entry: lut_update pulses one cycle, busy=0, go to RESP with err=0.
  - Route compute may observe a partially cleared table during CLEAR. This is acceptable.
- RESP:
  - rsp_valid=1 and cfg_ready=0.
  - rsp_data and rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: go to IDLE. The next command can be accepted the following cycle.
  - Minimum command-to-command spacing is 2 cycles.
- Latency:
  - write/read: response valid 1 cycle after accept.
  - clear-all: response valid NUM_ENTRIES+1 cycles after accept.
- cfg_* inputs are ignored whenever cfg_ready=0. No command is ever dropped silently or queued.
- Reset mid-CLEAR or mid-RESP:
  - table zeroed, pending response discarded;
  - no lut_update pulse is generated by the reset.
- Writing an identical value still pulses lut_update.
- Index compare is against NUM_ENTRIES, not against 2^index width.

Test Plan:
- Reset then write idx=3, req=0x05, dest=0x0A, out_sel=2:
  - cfg_ready drops;
  - next cycle lut_dest[3]=0x0A and lut_update=1;
  - rsp_valid=1, rsp_err=0.
- Read idx=3 after that write -> rsp_data={0x05,0x0A,0x02}, err=0.
  - Hold rsp_ready=0 for 5 cycles: response stays stable and cfg_ready stays 0.
- Write idx=32 -> err=1, no lut_update. Write idx=4 with out_sel=4 (NUM_OUTPORTS=4) -> err=1, entry 4 unchanged.
- Fill entries 0..31 with nonzero values, then clear-all:
  - busy high for 32 cycles;
  - all lut_* are 0 afterwards;
  - lut_update pulses once;
  - rsp_valid arrives 33 cycles after accept.
- Assert rst at clear-all cycle 10:
  - all outputs at reset values immediately (async);
  - after release, a read of idx=20 returns 0 and cfg_ready=1.
- op=11 -> err=1. Then back-to-back writes with rsp_ready tied 1 -> one accept every 2 cycles.
